step_counter: RTL and testbench

STEP_COUNTER -- requirements
Module: step_counter

---
 rtl/step_counter.sv | 98 +++++++++
 tb/tb_step_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/step_counter.sv
// Up/down step counter with load, wrap-or-saturate bounds and registered carry/borrow pulses.
// Saturation is enabled by defining STEP_COUNTER_SAT_EN; without it, sat is ignored and the count always wraps.
module step_counter #(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] MAX    = {WIDTH{1'b1}},
  parameter int unsigned      STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              load,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  d,
  input  logic              sat,
  output logic [WIDTH-1:0]  q,
  output logic              zero,
  output logic              at_max,
  output logic              carry,
  output logic              borrow
);

  localparam int unsigned EW = WIDTH + 1;

  logic [WIDTH-1:0] q_q, q_d;
  logic             zero_q, zero_d;
  logic             at_max_q, at_max_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             sat_en_c;

  // One extra bit keeps MAX+1 and q+step exact even when MAX is all ones.
  logic [EW-1:0] max_e, mod_e, q_e, step_e, sum_e, wrap_dn_e;

  assign max_e     = EW'(MAX);
  assign mod_e     = max_e + EW'(1);
  assign q_e       = EW'(q_q);
  assign step_e    = EW'(step);
  assign sum_e     = q_e + step_e;
  assign wrap_dn_e = q_e + mod_e - step_e;

`ifdef STEP_COUNTER_SAT_EN
  assign sat_en_c = sat;
`else
  assign sat_en_c = 1'b0 & sat;
`endif

  // Next-count selection: hold > load > down > up.
  always_comb begin
    q_d      = q_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    if (!ce) begin
      q_d = q_q;
    end else if (load) begin
      q_d = (d > MAX) ? MAX : d;
    end else if (down) begin
      if (step_e > q_e) begin
        borrow_d = 1'b1;
        q_d      = sat_en_c ? '0 : WIDTH'(wrap_dn_e);
      end else begin
        q_d = WIDTH'(q_e - step_e);
      end
    end else begin
      if (sum_e > max_e) begin
        carry_d = 1'b1;
        q_d     = sat_en_c ? MAX : WIDTH'(sum_e - mod_e);
      end else begin
        q_d = WIDTH'(sum_e);
      end
    end
    zero_d   = (q_d == '0);
    at_max_d = (q_d == MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q      <= '0;
      zero_q   <= 1'b1;
      at_max_q <= 1'b0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      zero_q   <= zero_d;
      at_max_q <= at_max_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign q      = q_q;
  assign zero   = zero_q;
  assign at_max = at_max_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter (WIDTH=8, MAX=9, STEP_W=3): vector table, directed saturation sequence, random vs model.
module tb_step_counter;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned STEP_W = 3;
  localparam int          MAXV   = 9;

  logic              clk = 1'b0;
  logic              reset, ce, load, down, sat;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  d;
  logic [WIDTH-1:0]  q;
  logic              zero, at_max, carry, borrow;

  int total = 0;
  int bad   = 0;

  step_counter #(.WIDTH(WIDTH), .MAX(8'(MAXV)), .STEP_W(STEP_W)) dut (
    .clk(clk), .reset(reset), .ce(ce), .load(load), .down(down), .step(step),
    .d(d), .sat(sat), .q(q), .zero(zero), .at_max(at_max), .carry(carry), .borrow(borrow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, ld, dn;
    int   st, dv;
    int   eq;
    logic ec, eb;
  } vec_t;

  function automatic vec_t mk(logic rst, logic en, logic ld, logic dn, int st, int dv,
                              int eq, logic ec, logic eb);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.dn = dn; v.st = st; v.dv = dv;
    v.eq = eq; v.ec = ec; v.eb = eb;
    return v;
  endfunction

  task automatic check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(string tag, int eq, logic ec, logic eb);
    check({tag, ".q"}, int'(q), eq);
    check({tag, ".zero"}, int'(zero), int'(eq == 0));
    check({tag, ".at_max"}, int'(at_max), int'(eq == MAXV));
    check({tag, ".carry"}, int'(carry), int'(ec));
    check({tag, ".borrow"}, int'(borrow), int'(eb));
  endtask

  task automatic cyc(logic rst, logic en, logic ld, logic dn, int st, int dv, logic s);
    reset = rst; ce = en; load = ld; down = dn;
    step = STEP_W'(st); d = WIDTH'(dv); sat = s;
    @(posedge clk);
    #1;
  endtask

  // Reference model state: count as a plain integer in 0..MAXV.
  int  mq;
  bit  mc, mb;
  bit  sat_en;

  task automatic model_step(bit rst, bit en, bit ld, bit dn, int st, int dv, bit s);
    int t;
    mc = 0; mb = 0;
    if (rst) mq = 0;
    else if (!en) mq = mq;
    else if (ld) mq = (dv > MAXV) ? MAXV : dv;
    else if (dn) begin
      t = mq - st;
      if (t < 0) begin
        mb = 1;
        mq = (sat_en && s) ? 0 : (t + MAXV + 1) % (MAXV + 1);
      end else mq = t;
    end else begin
      t = mq + st;
      if (t > MAXV) begin
        mc = 1;
        mq = (sat_en && s) ? MAXV : t % (MAXV + 1);
      end else mq = t;
    end
  endtask

  vec_t vt[21];

  initial begin
`ifdef STEP_COUNTER_SAT_EN
    sat_en = 1;
`else
    sat_en = 0;
`endif
    reset = 1'b1; ce = 1'b0; load = 1'b0; down = 1'b0; step = '0; d = '0; sat = 1'b0;

    //          rst ce ld dn st dv   q  c  b
    vt[0]  = mk(1, 1, 1, 0, 0, 5,    0, 0, 0);
    vt[1]  = mk(0, 1, 1, 0, 0, 8,    8, 0, 0);
    vt[2]  = mk(0, 1, 0, 0, 3, 0,    1, 1, 0);
    vt[3]  = mk(0, 0, 0, 0, 3, 0,    1, 0, 0);
    vt[4]  = mk(0, 1, 1, 0, 0, 2,    2, 0, 0);
    vt[5]  = mk(0, 1, 0, 1, 5, 0,    7, 0, 1);
    vt[6]  = mk(0, 1, 1, 0, 0, 5,    5, 0, 0);
    vt[7]  = mk(0, 1, 0, 1, 5, 0,    0, 0, 0);
    vt[8]  = mk(0, 1, 1, 0, 0, 200,  9, 0, 0);
    vt[9]  = mk(0, 1, 1, 1, 7, 4,    4, 0, 0);
    vt[10] = mk(0, 1, 1, 0, 0, 6,    6, 0, 0);
    vt[11] = mk(0, 1, 0, 0, 0, 0,    6, 0, 0);
    vt[12] = mk(0, 0, 0, 0, 7, 0,    6, 0, 0);
    vt[13] = mk(0, 1, 0, 0, 3, 0,    9, 0, 0);
    vt[14] = mk(0, 1, 0, 0, 1, 0,    0, 1, 0);
    vt[15] = mk(0, 1, 0, 1, 7, 0,    3, 0, 1);
    vt[16] = mk(0, 1, 0, 1, 3, 0,    0, 0, 0);
    vt[17] = mk(0, 1, 1, 0, 7, 9,    9, 0, 0);
    vt[18] = mk(0, 1, 0, 0, 7, 0,    6, 1, 0);
    vt[19] = mk(0, 1, 0, 0, 7, 0,    3, 1, 0);
    vt[20] = mk(1, 1, 0, 0, 7, 0,    0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 21; i++) begin
      cyc(vt[i].rst, vt[i].en, vt[i].ld, vt[i].dn, vt[i].st, vt[i].dv, 1'b0);
      check_all($sformatf("vec%0d", i), vt[i].eq, vt[i].ec, vt[i].eb);
    end

    // Saturation behaviour depends on the build option.
    cyc(0, 1, 1, 0, 0, 8, 1'b1);
    cyc(0, 1, 0, 0, 3, 0, 1'b1);
    check_all("sat_up", sat_en ? 9 : 1, 1'b1, 1'b0);
    cyc(0, 1, 1, 0, 0, 1, 1'b1);
    cyc(0, 1, 0, 1, 4, 0, 1'b1);
    check_all("sat_dn", sat_en ? 0 : 7, 1'b0, 1'b1);

    // Reset mid-sequence discards the pending update; next edge counts from 0.
    cyc(0, 1, 1, 0, 0, 5, 1'b0);
    cyc(1, 1, 0, 0, 2, 0, 1'b0);
    check_all("rst_mid", 0, 1'b0, 1'b0);
    cyc(0, 1, 0, 0, 2, 0, 1'b0);
    check_all("rst_after", 2, 1'b0, 1'b0);
    mq = 2;

    for (int n = 0; n < 600; n++) begin
      bit r, e, l, dn, s;
      int st, dv;
      r  = ($urandom_range(39) == 0);
      e  = ($urandom_range(3) != 0);
      l  = ($urandom_range(5) == 0);
      dn = $urandom_range(1);
      s  = $urandom_range(1);
      st = $urandom_range(7);
      dv = $urandom_range(255);
      cyc(r, e, l, dn, st, dv, s);
      model_step(r, e, l, dn, st, dv, s);
      check_all($sformatf("rnd%0d", n), mq, mc, mb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
